bcd_ms_timer: RTL
=================

Name: bcd_ms_timer

Overview:
- Millisecond stopwatch feeding the four-digit seven-segment decoder stage.
- Counts elapsed time in BCD from 0.000 s to 9.999 s under start/stop/clear control.
- Outputs are four registered BCD digits (`ones`, `tenths`, `hundreths`, `thousandths`) that connect directly to the decoder's same-named inputs.
- Sits between the game/reaction control FSM (issues start/stop/clear) and the display decoder.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_DIV, CLK_HZ/1000, clock cycles per 1 ms tick. Must be >= 2. Benches override it to a small value.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level-sampled each cycle; begins a new timing run from 0.000.
- stop  input  1  level-sampled; freezes the count.
- clear  input  1  level-sampled; returns to IDLE with digits at zero.
- ones  output  4  BCD seconds digit, 0-9.
- tenths  output  4  BCD 0.1 s digit, 0-9.
- hundreths  output  4  BCD 0.01 s digit, 0-9.
- thousandths  output  4  BCD 0.001 s digit, 0-9.
- running  output  1  high while in RUN.
- overflow  output  1  high while in OVER.

Behaviour:
- Clocking and reset:
  - One clock: `clk`. Reset is synchronous and active-high on `reset`.
  - Reset (and reset asserted mid-run) forces, at the next edge: state=IDLE, all digits=0, prescaler=0, `running`=0, `overflow`=0. Reset overrides all other inputs.
- States: IDLE, RUN, HOLD, OVER.
- Command priority in every state: `clear` > `stop` > `start`.
- Any state, `clear`=1: next state IDLE, digits=0, prescaler=0.
- IDLE:
  - `start`=1: digits=0, prescaler=0, next state RUN.
  - Otherwise hold.
- RUN:
  - `stop`=1: next state HOLD. Digits are frozen and the prescaler is not advanced; a tick coinciding with `stop` is discarded.
  - Else, if prescaler==TICK_DIV-1: prescaler=0 and the BCD count increments by 1 ms.
  - Else prescaler+1.
  - `start` in RUN is ignored; it does not restart the run.
- Increment rule:
  - `thousandths` +1. Each digit wraps 9->0 with carry into the next digit (`thousandths` -> `hundreths` -> `tenths` -> `ones`).
  - Digits never hold values 10-15.
- Saturation: a tick arriving at 9.999 leaves the digits at 9.999 and sets next state OVER. The digits never wrap to 0.000.
- HOLD:
  - Digits frozen.
  - `start` ignored; only `clear` or `reset` leaves HOLD.
  - `stop` has no effect.
- OVER:
  - Digits held at 9.999.
  - `start` and `stop` ignored; leave only via `clear` or `reset`.
- Latency:
  - With `start` sampled at edge N, `running`=1 after edge N.
  - First increment (0.001) is visible after edge N+TICK_DIV.
  - Thereafter the count advances every TICK_DIV cycles.
- Outputs:
  - All outputs are registered.
  - `running` = (state==RUN); `overflow` = (state==OVER).
- Widths:
  - Prescaler width is $clog2(TICK_DIV).
  - Digit registers are 4 bits each.

Decomposition:
- Shared package holds:
  - state enum: IDLE, RUN, HOLD, OVER.
  - constant BCD_MAX=4'd9.
  - function deriving TICK_DIV from CLK_HZ.
- Sub-module bcd_digit_counter: one decade digit with inputs clk, reset, clr, inc_in, and outputs digit[3:0], carry_out.
  - carry_out = inc_in && digit==9.
  - Instantiated four times in a carry chain.
  - Saturation detection (all four digits at 9 with a tick) lives in the top level and gates inc_in.

Test Plan:
- TICK_DIV=4; reset 3 cycles, then observe -> all digits 0, `running`=0, `overflow`=0.
- `start` pulse at edge N -> `running`=1 after N; digits 0.000 until N+4; 0.001 after N+4; 0.010 after N+40.
- Preload to 0.999 by running 3996 cycles, then one more tick -> digits 1.000, with the carry rippling through all four digits in a single cycle.
- Run to 9.999 (39996 cycles after start), then 4 more cycles -> digits stay 9.999, `overflow`=1, `running`=0; a `start` pulse afterwards causes no change.
- Assert `stop` on the same cycle as a tick at 0.005 -> state HOLD, digits remain 0.005 indefinitely; `start` ignored; `clear` -> 0.000 and IDLE.
- Assert `reset` mid-run at 0.123 together with `start`=1 -> next edge all digits 0 and IDLE; `start` held high afterwards -> RUN begins the cycle after `reset` is deasserted.

Source files
------------

// File: rtl/bcd_ms_timer_pkg.sv
// ---------------------------------------------------------------------------
// bcd_ms_timer_pkg : shared types and constants for the BCD millisecond timer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_ms_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int tick_div_from_clk(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter : one decade (0-9) digit with carry to the next decade
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit_counter
  import bcd_ms_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc_in) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign carry_out = inc_in && (digit_q == BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_ms_timer.sv
// ---------------------------------------------------------------------------
// bcd_ms_timer : 0.000-9.999 s BCD stopwatch with start/stop/clear control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_ms_timer
  import bcd_ms_timer_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_DIV = tick_div_from_clk(CLK_HZ)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] ones,
  output logic [3:0] tenths,
  output logic [3:0] hundreths,
  output logic [3:0] thousandths,
  output logic       running,
  output logic       overflow
);

  localparam int            PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            running_q, overflow_q;

  logic       tick;
  logic       all_nines;
  logic       digit_clr;
  logic [3:0] digit [0:3];
  logic       carry [0:4];

  assign tick      = (state_q == ST_RUN) && !clear && !stop && (ps_q == PS_LAST);
  assign all_nines = (digit[0] == BCD_MAX) && (digit[1] == BCD_MAX) &&
                     (digit[2] == BCD_MAX) && (digit[3] == BCD_MAX);
  assign digit_clr = clear || ((state_q == ST_IDLE) && start && !stop);

  // Saturation: the final tick at 9.999 never enters the carry chain.
  assign carry[0] = tick && !all_nines;

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (digit_clr),
      .inc_in    (carry[g]),
      .digit     (digit[g]),
      .carry_out (carry[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    ps_d    = ps_q;
    if (clear) begin
      state_d = ST_IDLE;
      ps_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stop && start) begin
            state_d = ST_RUN;
            ps_d    = '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_HOLD;
          end else if (ps_q == PS_LAST) begin
            ps_d = '0;
            if (all_nines) state_d = ST_OVER;
          end else begin
            ps_d = ps_q + 1'b1;
          end
        end
        ST_HOLD: state_d = ST_HOLD;
        ST_OVER: state_d = ST_OVER;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ps_q       <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      running_q  <= (state_d == ST_RUN);
      overflow_q <= (state_d == ST_OVER);
    end
  end

  assign thousandths = digit[0];
  assign hundreths   = digit[1];
  assign tenths      = digit[2];
  assign ones        = digit[3];
  assign running     = running_q;
  assign overflow    = overflow_q;

endmodule

`default_nettype wire
